// File: rtl/tlc_pkg.sv
// Shared encodings for the farm-road traffic-light design: sensor conditioner
// states plus controller light and state codes.
package tlc_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef logic [1:0] cond_state_t;
  typedef logic [1:0] light_t;
  typedef logic [2:0] ctrl_state_t;

  // Bit 1 is the accepted level, bit 0 flags a pending change.
  localparam cond_state_t LOW_STABLE  = 2'b00;
  localparam cond_state_t CHECK_HIGH  = 2'b01;
  localparam cond_state_t HIGH_STABLE = 2'b10;
  localparam cond_state_t CHECK_LOW   = 2'b11;

  localparam light_t LIGHT_RED    = 2'b01;
  localparam light_t LIGHT_YELLOW = 2'b10;
  localparam light_t LIGHT_GREEN  = 2'b11;

  localparam ctrl_state_t S0 = 3'd0;
  localparam ctrl_state_t S1 = 3'd1;
  localparam ctrl_state_t S2 = 3'd2;
  localparam ctrl_state_t S3 = 3'd3;
  localparam ctrl_state_t S4 = 3'd4;
  localparam ctrl_state_t S5 = 3'd5;

endpackage

// File: rtl/farm_sensor_conditioner_if.sv
// Sensor-side bundle: raw pin in, conditioned level, edge pulses and debug state out.
interface farm_sensor_conditioner_if;
  import tlc_pkg::*;

  logic        rawSensor;
  logic        farmSensor;
  logic        sensorRise;
  logic        sensorFall;
  cond_state_t state;

  // master drives the raw pin and observes; slave is the conditioner itself.
  modport master (output rawSensor, input farmSensor, input sensorRise,
                  input sensorFall, input state);
  modport slave  (input rawSensor, output farmSensor, output sensorRise,
                  output sensorFall, output state);

endinterface

// File: rtl/farm_sensor_conditioner_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset to 0; also used
// for the highway reset button.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Synchronises and debounces the farm-road vehicle sensor, producing a clean
// registered level plus one-cycle rise/fall pulses.
module farm_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                      Clk,
  input  logic                      Rst,
  farm_sensor_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("farm_sensor_conditioner: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic             sync_level;
  cond_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             farm_reg, farm_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  sync_2ff u_sync (
    .clk (Clk),
    .rst (Rst),
    .d   (bus.rawSensor),
    .q   (sync_level)
  );

  // The counter only runs inside a CHECK state and is cleared on every entry,
  // so it can never pass COUNT_LAST.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    farm_next  = farm_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      LOW_STABLE: begin
        if (sync_level) begin
          state_next = CHECK_HIGH;
          count_next = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync_level) begin
          state_next = LOW_STABLE;
        end else if (count_reg == COUNT_LAST) begin
          state_next = HIGH_STABLE;
          farm_next  = 1'b1;
          rise_next  = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!sync_level) begin
          state_next = CHECK_LOW;
          count_next = '0;
        end
      end
      CHECK_LOW: begin
        if (sync_level) begin
          state_next = HIGH_STABLE;
        end else if (count_reg == COUNT_LAST) begin
          state_next = LOW_STABLE;
          farm_next  = 1'b0;
          fall_next  = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = LOW_STABLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= LOW_STABLE;
      count_reg <= '0;
      farm_reg  <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      farm_reg  <= farm_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign bus.farmSensor = farm_reg;
  assign bus.sensorRise = rise_reg;
  assign bus.sensorFall = fall_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed bench for farm_sensor_conditioner: behavioural run-length model
// compared every cycle, plus literal latency checks.
module tb_farm_sensor_conditioner;
  import tlc_pkg::*;

  localparam int D = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  farm_sensor_conditioner_if bus ();

  farm_sensor_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Model: the FSM sees the pin two samples late; the level flips once the
  // delayed input has held a new value for D+1 consecutive samples.
  bit   hist[$];
  bit   m_farm, m_rise, m_fall, m_dv, last_dv;
  int   run;
  logic [1:0] m_state;

  initial begin
    forever begin
      @(posedge Clk or posedge Rst);
      if (Rst) begin
        hist.delete();
        m_farm = 0; m_rise = 0; m_fall = 0; last_dv = 0; run = D + 1;
        m_state = LOW_STABLE;
      end else begin
        hist.push_back(bus.rawSensor);
        if (hist.size() > 3) void'(hist.pop_front());
        m_dv = (hist.size() >= 3) ? hist[0] : 1'b0;
        if (m_dv == last_dv) run++;
        else begin
          run = 1;
          last_dv = m_dv;
        end
        m_rise = 0;
        m_fall = 0;
        if (m_dv != m_farm && run >= D + 1) begin
          m_farm = m_dv;
          m_rise = m_dv;
          m_fall = !m_dv;
        end
        m_state = {m_farm, m_dv ^ m_farm};
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        chk("model_farm", bus.farmSensor, m_farm);
        chk("model_rise", bus.sensorRise, m_rise);
        chk("model_fall", bus.sensorFall, m_fall);
        chk("model_state", bus.state, m_state);
      end
    end
  end

  initial begin
    bus.rawSensor = 1'b0;
    #1;
    // reset state while held
    chk("rst_farm", bus.farmSensor, 0);
    chk("rst_state", bus.state, LOW_STABLE);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // accept edge
    @(negedge Clk); bus.rawSensor = 1'b1;
    tick(1);
    tick(5);
    chk("acc_pre_farm", bus.farmSensor, 0);
    chk("acc_pre_state", bus.state, CHECK_HIGH);
    tick(1);
    chk("acc_farm", bus.farmSensor, 1);
    chk("acc_rise", bus.sensorRise, 1);
    tick(1);
    chk("acc_rise_end", bus.sensorRise, 0);
    chk("acc_state", bus.state, HIGH_STABLE);

    // asynchronous reset with no clock edge, then full re-debounce
    @(negedge Clk); #2; Rst = 1'b1; #1;
    chk("async_farm", bus.farmSensor, 0);
    chk("async_rise", bus.sensorRise, 0);
    chk("async_fall", bus.sensorFall, 0);
    chk("async_state", bus.state, LOW_STABLE);
    @(negedge Clk); @(negedge Clk); Rst = 1'b0;
    tick(1);
    tick(5);
    chk("rerun_pre_farm", bus.farmSensor, 0);
    tick(1);
    chk("rerun_farm", bus.farmSensor, 1);

    @(negedge Clk); bus.rawSensor = 1'b0;
    tick(12);
    chk("low_farm", bus.farmSensor, 0);

    // 4-cycle pulse rejected
    @(negedge Clk); bus.rawSensor = 1'b1;
    repeat (4) @(negedge Clk);
    bus.rawSensor = 1'b0;
    tick(10);
    chk("glitch4_farm", bus.farmSensor, 0);
    chk("glitch4_state", bus.state, LOW_STABLE);

    // 5-cycle pulse accepted, then its release debounced
    @(negedge Clk); bus.rawSensor = 1'b1;
    repeat (5) @(negedge Clk);
    bus.rawSensor = 1'b0;
    tick(1);
    chk("p5_pre_farm", bus.farmSensor, 0);
    tick(1);
    chk("p5_farm", bus.farmSensor, 1);
    chk("p5_rise", bus.sensorRise, 1);
    tick(4);
    chk("rel_pre_farm", bus.farmSensor, 1);
    tick(1);
    chk("rel_farm", bus.farmSensor, 0);
    chk("rel_fall", bus.sensorFall, 1);
    tick(1);
    chk("rel_fall_end", bus.sensorFall, 0);
    chk("rel_state", bus.state, LOW_STABLE);

    // 3-cycle blip
    @(negedge Clk); bus.rawSensor = 1'b1;
    repeat (3) @(negedge Clk);
    bus.rawSensor = 1'b0;
    tick(10);
    chk("blip_farm", bus.farmSensor, 0);

    // bounce for 40 cycles then settle high
    @(negedge Clk);
    for (int i = 0; i < 20; i++) begin
      bus.rawSensor = ~i[0];
      repeat (2) @(negedge Clk);
    end
    chk("bounce_farm", bus.farmSensor, 0);
    bus.rawSensor = 1'b1;
    tick(1);
    tick(5);
    chk("settle_pre_farm", bus.farmSensor, 0);
    tick(1);
    chk("settle_farm", bus.farmSensor, 1);
    chk("settle_rise", bus.sensorRise, 1);

    // reset mid CHECK_HIGH with counter at 2
    @(negedge Clk); bus.rawSensor = 1'b0;
    tick(12);
    chk("pre6_farm", bus.farmSensor, 0);
    @(negedge Clk); bus.rawSensor = 1'b1;
    tick(1);
    tick(4);
    chk("mid_state", bus.state, CHECK_HIGH);
    #3; Rst = 1'b1; #1;
    chk("mid_rst_state", bus.state, LOW_STABLE);
    @(negedge Clk); @(negedge Clk); Rst = 1'b0;
    tick(1);
    tick(5);
    chk("post_rst_pre_farm", bus.farmSensor, 0);
    tick(1);
    chk("post_rst_farm", bus.farmSensor, 1);
    chk("post_rst_rise", bus.sensorRise, 1);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/farm_sensor_conditioner.md
Name: farm_sensor_conditioner

Overview:
Conditions the raw farm-road vehicle sensor (switch/loop detector) before it reaches the traffic-light controller FSM. It synchronises the asynchronous input into the Clk domain and debounces it with a counter-driven FSM. It then drives the clean, registered farmSensor level that the controller samples. It also emits one-cycle rise/fall pulses for event logging and debug.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); legal range ≥ 2
CNT_W, 20, debounce counter width; 2**CNT_W must exceed DEBOUNCE_CYCLES

Ports:
Clk  input  1  system clock, 50 MHz
Rst  input  1  asynchronous, active-high reset
rawSensor  input  1  unsynchronised sensor from board pin
farmSensor  output  1  debounced, registered sensor level to controller
sensorRise  output  1  one-cycle pulse, coincident with farmSensor 0→1
sensorFall  output  1  one-cycle pulse, coincident with farmSensor 1→0
state  output  2  current FSM state, for debugging

Behaviour:
- Reset: one clock; Rst is asynchronous and active-high. While Rst=1 the following hold:
  - sync1=sync2=0, counter=0, state=LOW_STABLE (2'b00)
  - farmSensor=0, sensorRise=0, sensorFall=0
- Synchroniser: two flops, rawSensor→sync1→sync2. Only sync2 is used by the FSM.
- FSM states:
  - LOW_STABLE=00, CHECK_HIGH=01, HIGH_STABLE=10, CHECK_LOW=11
- LOW_STABLE: if sync2=1 → CHECK_HIGH with counter←0; else stay.
- CHECK_HIGH:
  - if sync2=0 → LOW_STABLE (glitch rejected; no output change)
  - elif counter==DEBOUNCE_CYCLES-1 → HIGH_STABLE; farmSensor←1, sensorRise←1 for one cycle
  - else counter←counter+1
- HIGH_STABLE and CHECK_LOW mirror the above with polarity inverted. The accept transition sets farmSensor←0 and pulses sensorFall.
- Latency: let k0 be the first edge at which sync1 samples the new level. farmSensor changes at edge k0+DEBOUNCE_CYCLES+2.
- Minimum accepted pulse width is DEBOUNCE_CYCLES+1 clock cycles. A pulse of DEBOUNCE_CYCLES cycles or fewer produces no output change.
- Counter resets to 0 on every entry into a CHECK state. It never wraps and saturates logically at DEBOUNCE_CYCLES-1.
- At most one of sensorRise/sensorFall is asserted in any cycle. Neither asserts without a farmSensor change.
- Bouncing input (alternating faster than the window): FSM oscillates between the STABLE and CHECK states; farmSensor holds its value.
- Reset mid-check: all state is discarded. If rawSensor is still high after release, a full debounce restarts from LOW_STABLE; there is no partial credit.
- farmSensor, sensorRise, sensorFall and state are all registered outputs; no combinational path from rawSensor.

Decomposition:
- Shared package tlc_pkg holds:
  - CLK_HZ = 50_000_000
  - the conditioner state encodings (LOW_STABLE..CHECK_LOW)
  - the controller light codes (red=01, yellow=10, green=11) and the controller state codes S0–S5, so benches decode both blocks from one source
- One natural sub-module: sync_2ff (two-flop synchroniser, async active-high reset to 0), reusable for the highway reset button.

Test Plan:
1. Reset: assert Rst mid-cycle (asynchronous) → farmSensor=0, pulses=0, state=00 immediately, without waiting for a Clk edge.
2. Accept edge: DEBOUNCE_CYCLES=4, rawSensor 0→1 held high, k0 = first sampling edge → farmSensor=1 and sensorRise=1 at edge k0+6. sensorRise=0 at k0+7 and state=10.
3. Glitch rejection: DEBOUNCE_CYCLES=4, rawSensor high for exactly 4 cycles → farmSensor stays 0, no pulse, state returns to 00. Repeat with a 5-cycle pulse → farmSensor=1 at k0+6.
4. Release debounce: from HIGH_STABLE, rawSensor→0 held low → farmSensor=0 and sensorFall=1 for one cycle at k0+6. Then a 3-cycle high blip → farmSensor stays 0.
5. Bounce: rawSensor toggles every 2 cycles for 40 cycles, then settles high → no output change during the bounce. farmSensor=1 exactly 6 edges after the final settle's k0.
6. Reset mid-operation: Rst pulsed during CHECK_HIGH with counter=2, rawSensor kept high → after release, farmSensor rises exactly DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
